// File: rtl/time_count_decoder.sv
// -----------------------------------------------------------------------------
// time_count_decoder
//   Turns a raw 100 Hz tick count (centiseconds since epoch) into
//   days / hours / minutes / seconds / centiseconds for display. A single
//   restoring shift-subtract datapath is reused for four constant divides
//   (100, 60, 60, 24), one quotient bit per clock, MSB first.
//
// Ports
//   clockSignal   in   system clock, rising edge
//   resetN        in   asynchronous active-low reset
//   start         in   request conversion of countIn (honoured only when idle)
//   countIn       in   COUNT_W-bit tick count, captured on the accepting edge
//   busy          out  conversion in progress (includes the done cycle)
//   done          out  one-cycle pulse, result outputs freshly updated
//   centiseconds  out  0..99
//   seconds       out  0..59
//   minutes       out  0..59
//   hours         out  0..23
//   days          out  whole days, COUNT_W bits
//
// Timing (edge 0 = start accepted): each divide stage takes COUNT_W edges,
// the DONE state spends one more edge loading the output registers and
// raising done, so done is high after edge 4*COUNT_W+1 and busy drops on
// the following edge.
// -----------------------------------------------------------------------------
module time_count_decoder #(
  parameter int COUNT_W = 64
) (
  input  logic               clockSignal,
  input  logic               resetN,
  input  logic               start,
  input  logic [COUNT_W-1:0] countIn,
  output logic               busy,
  output logic               done,
  output logic [6:0]         centiseconds,
  output logic [5:0]         seconds,
  output logic [5:0]         minutes,
  output logic [4:0]         hours,
  output logic [COUNT_W-1:0] days
);

  localparam int CNT_W = (COUNT_W > 2) ? $clog2(COUNT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(COUNT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIV100 = 3'd1,
    S_DIV60S = 3'd2,
    S_DIV60M = 3'd3,
    S_DIV24  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] dividend_q, dividend_d;  // dividend in, quotient out
  logic [7:0]         rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // stage results, latched as each divide finishes
  logic [6:0]         cs_q, cs_d;
  logic [5:0]         s_q, s_d;
  logic [5:0]         m_q, m_d;
  logic [4:0]         h_q, h_d;

  // display-facing registers, only touched in DONE
  logic [6:0]         cs_out_q, cs_out_d;
  logic [5:0]         s_out_q, s_out_d;
  logic [5:0]         m_out_q, m_out_d;
  logic [4:0]         h_out_q, h_out_d;
  logic [COUNT_W-1:0] days_out_q, days_out_d;

  // shared divide step
  logic [7:0]         divisor;
  logic [8:0]         rem_sh;
  logic               ge;
  logic [7:0]         rem_nx;
  logic [COUNT_W-1:0] quo_nx;
  logic               last;

  always_comb begin
    unique case (state_q)
      S_DIV60S, S_DIV60M: divisor = 8'd60;
      S_DIV24:            divisor = 8'd24;
      default:            divisor = 8'd100;
    endcase
    // rem < divisor <= 100, so the 9-bit shifted value never exceeds 199;
    // the subtraction result fits back into 8 bits.
    rem_sh = {rem_q, dividend_q[COUNT_W-1]};
    ge     = (rem_sh >= {1'b0, divisor});
    rem_nx = ge ? (rem_sh[7:0] - divisor) : rem_sh[7:0];
    quo_nx = {dividend_q[COUNT_W-2:0], ge};
    last   = (cnt_q == LAST_BIT);
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cs_d       = cs_q;
    s_d        = s_q;
    m_d        = m_q;
    h_d        = h_q;
    cs_out_d   = cs_out_q;
    s_out_d    = s_out_q;
    m_out_d    = m_out_q;
    h_out_d    = h_out_q;
    days_out_d = days_out_q;

    // busy stays up through the done cycle and drops right after it
    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // busy_q still high during the done cycle blocks a too-early start
        if (start && !busy_q) begin
          dividend_d = countIn;
          rem_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_DIV100;
        end
      end

      S_DIV100, S_DIV60S, S_DIV60M, S_DIV24: begin
        dividend_d = quo_nx;
        rem_d      = rem_nx;
        cnt_d      = cnt_q + 1'b1;
        if (last) begin
          // quotient stays in dividend_q as the next stage's input
          rem_d = '0;
          cnt_d = '0;
          unique case (state_q)
            S_DIV100: begin cs_d = rem_nx[6:0]; state_d = S_DIV60S; end
            S_DIV60S: begin s_d  = rem_nx[5:0]; state_d = S_DIV60M; end
            S_DIV60M: begin m_d  = rem_nx[5:0]; state_d = S_DIV24;  end
            default:  begin h_d  = rem_nx[4:0]; state_d = S_DONE;   end
          endcase
        end
      end

      S_DONE: begin
        cs_out_d   = cs_q;
        s_out_d    = s_q;
        m_out_d    = m_q;
        h_out_d    = h_q;
        days_out_d = dividend_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      dividend_q <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= '0;
      s_q        <= '0;
      m_q        <= '0;
      h_q        <= '0;
      cs_out_q   <= '0;
      s_out_q    <= '0;
      m_out_q    <= '0;
      h_out_q    <= '0;
      days_out_q <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      s_q        <= s_d;
      m_q        <= m_d;
      h_q        <= h_d;
      cs_out_q   <= cs_out_d;
      s_out_q    <= s_out_d;
      m_out_q    <= m_out_d;
      h_out_q    <= h_out_d;
      days_out_q <= days_out_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign centiseconds = cs_out_q;
  assign seconds      = s_out_q;
  assign minutes      = m_out_q;
  assign hours        = h_out_q;
  assign days         = days_out_q;

endmodule
